// File: rtl/mul_pkg.sv
// Shared types and helpers for the radix-16 Booth multiplier blocks.
// Multiple width grows by 3 bits for 8M plus one sign bit.
package mul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC3,
    CALC5,
    CALC7,
    READY
  } booth16_mg_state_t;

  localparam int BOOTH16_GROWTH_BITS = 4;

  function automatic int booth16_mw(int w);
    return w + BOOTH16_GROWTH_BITS;
  endfunction

endpackage

// File: rtl/booth16_addsub.sv
// Combinational W-bit wrap-around adder/subtractor: sum = sub ? a - b : a + b.
// Zero latency; no flow control.
module booth16_addsub #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth16_multiple_gen.sv
// Captures a multiplicand and precomputes the hard multiples 3M/5M/7M on one adder.
// Accept at t -> out_valid at t+4; new operands are refused while computing.
module booth16_multiple_gen
  import mul_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int MW    = booth16_mw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  // "release" is a reserved word in SystemVerilog, hence the suffix
  input  logic             release_i,
  output logic             out_valid,
  output logic [MW-1:0]    mult_1,
  output logic [MW-1:0]    mult_2,
  output logic [MW-1:0]    mult_3,
  output logic [MW-1:0]    mult_4,
  output logic [MW-1:0]    mult_5,
  output logic [MW-1:0]    mult_6,
  output logic [MW-1:0]    mult_7,
  output logic [MW-1:0]    mult_8
);

  booth16_mg_state_t state_q;
  logic [MW-1:0]     m_q;
  logic [MW-1:0]     m3_q;
  logic [MW-1:0]     m5_q;
  logic [MW-1:0]     m7_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [MW-1:0]     m_ext_d;
  logic [MW-1:0]     add_a;
  logic [MW-1:0]     add_b;
  logic              add_sub;
  logic [MW-1:0]     add_sum;

  assign m_ext_d = in_signed ? {{(MW-WIDTH){din[WIDTH-1]}}, din}
                             : {{(MW-WIDTH){1'b0}}, din};

  always_comb begin
    add_a   = m_q;
    add_b   = m_q << 1;
    add_sub = 1'b0;
    unique case (state_q)
      CALC5: add_b = m_q << 2;
      CALC7: begin
        add_a   = m_q << 3;
        add_b   = m_q;
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  booth16_addsub #(.W(MW)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  // clear only moves the FSM; captured values stay so a held result is not disturbed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      m3_q        <= '0;
      m5_q        <= '0;
      m7_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (clear) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE, READY: begin
          if (in_valid) begin
            m_q         <= m_ext_d;
            state_q     <= CALC3;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
          end else if (release_i && (state_q == READY)) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        CALC3: begin
          m3_q    <= add_sum;
          state_q <= CALC5;
        end
        CALC5: begin
          m5_q    <= add_sum;
          state_q <= CALC7;
        end
        CALC7: begin
          m7_q        <= add_sum;
          state_q     <= READY;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  assign mult_1 = m_q;
  assign mult_2 = m_q << 1;
  assign mult_3 = m3_q;
  assign mult_4 = m_q << 2;
  assign mult_5 = m5_q;
  assign mult_6 = m3_q << 1;
  assign mult_7 = m7_q;
  assign mult_8 = m_q << 3;

endmodule

// File: tb/tb_booth16_multiple_gen.sv
// Directed and randomized bench for booth16_multiple_gen against an arithmetic model.
module tb_booth16_multiple_gen;

  localparam int WIDTH = 8;
  localparam int MW    = WIDTH + 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] din;
  logic             clear;
  logic             release_i;
  logic             out_valid;
  logic [MW-1:0]    mult_1, mult_2, mult_3, mult_4, mult_5, mult_6, mult_7, mult_8;
  logic [MW-1:0]    got [1:8];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model: multiplicand value, remaining compute cycles, result-valid and outputs-known flags
  int m_val = 0;
  int busy  = 0;
  bit ready = 1'b0;
  bit known = 1'b0;

  booth16_multiple_gen #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .din       (din),
    .clear     (clear),
    .release_i (release_i),
    .out_valid (out_valid),
    .mult_1    (mult_1),
    .mult_2    (mult_2),
    .mult_3    (mult_3),
    .mult_4    (mult_4),
    .mult_5    (mult_5),
    .mult_6    (mult_6),
    .mult_7    (mult_7),
    .mult_8    (mult_8)
  );

  assign got[1] = mult_1;
  assign got[2] = mult_2;
  assign got[3] = mult_3;
  assign got[4] = mult_4;
  assign got[5] = mult_5;
  assign got[6] = mult_6;
  assign got[7] = mult_7;
  assign got[8] = mult_8;

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] exp_mult(int k);
    logic [MW-1:0] r;
    r = MW'(k * m_val);
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, return at the falling edge.
  task automatic cycle(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d,
                       input bit c, input bit rl);
    rst = r; in_valid = v; in_signed = s; din = d; clear = c; release_i = rl;
    @(posedge clk);
    cyc++;
    if (r) begin
      busy = 0; ready = 1'b0; m_val = 0; known = 1'b1;
    end else if (c) begin
      if (busy != 0) known = 1'b0;
      busy = 0; ready = 1'b0;
    end else if (v && busy == 0) begin
      m_val = s ? int'($signed(d)) : int'(d);
      busy = 3; ready = 1'b0; known = 1'b0;
    end else if (busy != 0) begin
      busy--;
      if (busy == 0) begin ready = 1'b1; known = 1'b1; end
    end else if (rl && ready) begin
      ready = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, 0, 0);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, '0, 0, 0);
    cycle(1, 0, 0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (got[k] !== '0) begin failures++; $display("FAIL reset_mult_%0d got=%h exp=0", k, got[k]); end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      idle();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || mult_1 !== '0 || mult_7 !== '0) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d ov=%b ir=%b m1=%h m7=%h exp ov=0 ir=1 m=0",
                 cyc, out_valid, in_ready, mult_1, mult_7);
      end
    end
  endtask

  task automatic test_unsigned_small();
    logic [MW-1:0] e;
    cycle(0, 1, 0, 8'h05, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL u05_latency t+%0d got=%b exp=0", i, out_valid); end
      idle();
    end
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL u05_valid_t4 got=%b exp=1", out_valid); end
    for (int k = 1; k <= 8; k++) begin
      e = MW'(5 * k);
      checks++;
      if (got[k] !== e) begin failures++; $display("FAIL u05_mult_%0d got=%h exp=%h", k, got[k], e); end
    end
    for (int i = 0; i < 20; i++) begin
      idle();
      checks++;
      if (out_valid !== 1'b1 || mult_3 !== 12'd15 || mult_7 !== 12'd35) begin
        failures++;
        $display("FAIL u05_hold cyc=%0d ov=%b m3=%h m7=%h exp ov=1 m3=00f m7=023", cyc, out_valid, mult_3, mult_7);
      end
    end
  endtask

  task automatic test_signed_extremes();
    cycle(0, 1, 1, 8'h80, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL s80_reload_t1 ov=%b ir=%b exp ov=0 ir=0", out_valid, in_ready);
    end
    repeat (3) idle();
    checks++;
    if (out_valid !== 1'b1 || mult_1 !== 12'hF80 || mult_3 !== 12'hE80 || mult_7 !== 12'hC80 ||
        mult_8 !== 12'hC00) begin
      failures++;
      $display("FAIL s80_mults ov=%b m1=%h m3=%h m7=%h m8=%h exp ov=1 f80 e80 c80 c00",
               out_valid, mult_1, mult_3, mult_7, mult_8);
    end
    checks++;
    if (mult_5 !== 12'hD80 || mult_6 !== 12'hD00) begin
      failures++; $display("FAIL s80_m5m6 m5=%h m6=%h exp d80 d00", mult_5, mult_6);
    end
    cycle(0, 1, 1, 8'h7F, 0, 0);
    repeat (3) idle();
    checks++;
    if (out_valid !== 1'b1 || mult_7 !== 12'h379 || mult_8 !== 12'h3F8) begin
      failures++; $display("FAIL s7f_mults ov=%b m7=%h m8=%h exp ov=1 379 3f8", out_valid, mult_7, mult_8);
    end
  endtask

  task automatic test_unsigned_max();
    cycle(0, 1, 0, 8'hFF, 0, 0);
    repeat (3) idle();
    checks++;
    if (out_valid !== 1'b1 || mult_1 !== 12'h0FF || mult_7 !== 12'h6F9 || mult_8 !== 12'h7F8) begin
      failures++;
      $display("FAIL uff_mults ov=%b m1=%h m7=%h m8=%h exp ov=1 0ff 6f9 7f8", out_valid, mult_1, mult_7, mult_8);
    end
  endtask

  task automatic test_back_to_back();
    cycle(0, 0, 0, '0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL release_to_idle ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    cycle(0, 1, 0, 8'h11, 0, 0);
    idle();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
    cycle(0, 1, 0, 8'h22, 0, 0);
    cycle(0, 1, 0, 8'h22, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || mult_1 !== 12'h011 || mult_7 !== 12'h077) begin
      failures++; $display("FAIL busy_ignore ov=%b m1=%h m7=%h exp ov=1 011 077", out_valid, mult_1, mult_7);
    end
    cycle(0, 1, 0, 8'h33, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL reload_beats_release ov=%b ir=%b exp ov=0 ir=0", out_valid, in_ready);
    end
    repeat (3) idle();
    checks++;
    if (out_valid !== 1'b1 || mult_1 !== 12'h033 || mult_5 !== 12'h0FF) begin
      failures++; $display("FAIL reload_result ov=%b m1=%h m5=%h exp ov=1 033 0ff", out_valid, mult_1, mult_5);
    end
    cycle(0, 0, 0, '0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mult_5 !== 12'h0FF) begin
      failures++; $display("FAIL release_alone ov=%b ir=%b m5=%h exp ov=0 ir=1 0ff", out_valid, in_ready, mult_5);
    end
  endtask

  task automatic test_abort();
    bit pulsed;
    pulsed = 1'b0;
    cycle(0, 1, 0, 8'h44, 0, 0);
    idle();
    cycle(0, 0, 0, '0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL clear_calc5 ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    for (int i = 0; i < 6; i++) begin idle(); if (out_valid) pulsed = 1'b1; end
    cycle(0, 1, 0, 8'h55, 1, 0);
    for (int i = 0; i < 6; i++) begin idle(); if (out_valid) pulsed = 1'b1; end
    checks++;
    if (pulsed) begin failures++; $display("FAIL clear_no_pulse got=1 exp=0"); end
    cycle(0, 1, 1, 8'h66, 0, 0);
    idle();
    idle();
    cycle(1, 0, 0, '0, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_calc7 ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (got[k] !== '0) begin failures++; $display("FAIL rst_calc7_mult_%0d got=%h exp=0", k, got[k]); end
    end
    pulsed = 1'b0;
    for (int i = 0; i < 6; i++) begin idle(); if (out_valid) pulsed = 1'b1; end
    checks++;
    if (pulsed) begin failures++; $display("FAIL rst_no_pulse got=1 exp=0"); end
  endtask

  task automatic test_random();
    bit r, v, s, c, rl;
    logic [WIDTH-1:0] d;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 79) == 0);
      c  = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 2) == 0);
      s  = $urandom_range(0, 1) == 1;
      rl = ($urandom_range(0, 3) == 0);
      d  = WIDTH'($urandom);
      cycle(r, v, s, d, c, rl);
      checks++;
      if (out_valid !== ready) begin
        failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ready);
      end
      checks++;
      if (in_ready !== (busy == 0)) begin
        failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, busy == 0);
      end
      if (known) begin
        for (int k = 1; k <= 8; k++) begin
          checks++;
          if (got[k] !== exp_mult(k)) begin
            failures++;
            $display("FAIL rnd_mult_%0d cyc=%0d m=%0d got=%h exp=%h", k, cyc, m_val, got[k], exp_mult(k));
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; din = '0; clear = 1'b0; release_i = 1'b0;
    test_reset();
    test_idle();
    test_unsigned_small();
    test_signed_extremes();
    test_unsigned_max();
    test_back_to_back();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
